// File: rtl/pb_key_pkg.sv
// Shared definitions for the pushbutton key queue.
//   KEY_W          : width of a key code (index of a pushbutton, up to 32 buttons)
//   DEF_*          : default parameter values used by pb_key_queue
//   DB_CNT_W       : width of a per-button debounce counter (DB_SAMPLES <= 15)
//   key_code_t     : key code type
//   lowest_set()   : index of the lowest set bit of a 32-bit vector (0 if none)
package pb_key_pkg;

  localparam int KEY_W          = 5;
  localparam int DEF_NUM_PB     = 21;
  localparam int DEF_TICK_DIV   = 1;
  localparam int DEF_DB_SAMPLES = 3;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DB_CNT_W       = 4;

  typedef logic [KEY_W-1:0] key_code_t;

  // Scanning from the top down leaves the lowest set index in idx.
  function automatic key_code_t lowest_set(input logic [31:0] v);
    key_code_t idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = i[KEY_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// First-word fall-through FIFO for key codes.
//   clk, nrst : clock, asynchronous active-low reset
//   push_i    : write din_i (ignored when full unless a pop happens in the same cycle)
//   din_i     : data to write
//   pop_i     : remove head entry (ignored when empty)
//   full_o    : occupancy == DEPTH
//   empty_o   : occupancy == 0
//   dout_o    : head entry, forced to 0 while empty
//   count_o   : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module key_fifo #(
  parameter int  DEPTH = 4,
  parameter int  W     = 5,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read from it while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/pb_key_queue.sv
// Pushbutton front end: turns a raw pushbutton bus into key-press events.
// Pipeline: 2-flop synchroniser -> per-button debounce on a sample tick ->
// rising-edge (press) detect into a pending set -> lowest-index arbiter ->
// FWFT key FIFO read by the consumer.
//   clk        : system clock, rising edge
//   nrst       : asynchronous active-low reset
//   pb         : raw pushbuttons, active high, asynchronous to clk
//   key_ready  : consumer accepts the head entry this cycle
//   clear_ovf  : synchronous clear of overflow (a same-cycle set wins)
//   key_valid  : FIFO non-empty
//   key_code   : button index at the FIFO head (0 when empty)
//   key_count  : FIFO occupancy
//   overflow   : sticky, a repeat press of a still-pending key was dropped
// Handshake: an entry transfers on a cycle where key_valid && key_ready;
// key_valid never depends on key_ready, and key_code holds its value while
// key_valid && !key_ready.
module pb_key_queue
  import pb_key_pkg::*;
#(
  parameter int  NUM_PB     = DEF_NUM_PB,
  parameter int  TICK_DIV   = DEF_TICK_DIV,
  parameter int  DB_SAMPLES = DEF_DB_SAMPLES,
  parameter int  FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [NUM_PB-1:0] pb,
  input  logic              key_ready,
  input  logic              clear_ovf,
  output logic              key_valid,
  output logic [KEY_W-1:0]  key_code,
  output logic [CNT_W-1:0]  key_count,
  output logic              overflow
);

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_SAMPLES - 1);

  logic [NUM_PB-1:0]   sync1_q, sync2_q;
  logic                tick;
  logic [NUM_PB-1:0]   db_q, db_d;
  logic [DB_CNT_W-1:0] cnt_q [NUM_PB];
  logic [DB_CNT_W-1:0] cnt_d [NUM_PB];
  logic [NUM_PB-1:0]   rise;
  logic [NUM_PB-1:0]   pending_q, pending_d;
  logic [NUM_PB-1:0]   push_mask;
  logic [31:0]         pend_pad;
  key_code_t           push_idx;
  logic                push, pop;
  logic                fifo_full, fifo_empty;
  logic                ovf_q, ovf_d;
  logic                ovf_set;

  // Synchroniser for the asynchronous buttons.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pb;
      sync2_q <= sync1_q;
    end
  end

  // Debounce sample tick: one cycle in every TICK_DIV.
  generate
    if (TICK_DIV == 1) begin : g_tick_always
      assign tick = 1'b1;
    end else begin : g_tick_div
      localparam int TW = $clog2(TICK_DIV);
      logic [TW-1:0] div_q, div_d;
      assign tick  = (div_q == TW'(TICK_DIV - 1));
      assign div_d = tick ? '0 : div_q + 1'b1;
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) div_q <= '0;
        else       div_q <= div_d;
      end
    end
  endgenerate

  // Per-button debounce: a bit flips only after DB_SAMPLES consecutive
  // samples that disagree with it; any agreeing sample restarts the count.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NUM_PB; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (sync2_q[i] != db_q[i]) begin
          if (cnt_q[i] == DB_LAST) begin
            db_d[i]  = sync2_q[i];
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      db_q <= '0;
      for (int i = 0; i < NUM_PB; i++) cnt_q[i] <= '0;
    end else begin
      db_q <= db_d;
      for (int i = 0; i < NUM_PB; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // A press is registered on the same edge the debounced bit rises.
  assign rise = db_d & ~db_q;

  // Arbiter: lowest pending index goes to the FIFO whenever there is room,
  // including a full FIFO that is being popped this cycle.
  assign pop  = key_valid && key_ready;
  assign push = (|pending_q) && (!fifo_full || pop);

  always_comb begin
    pend_pad               = '0;
    pend_pad[NUM_PB-1:0]   = pending_q;
    push_idx               = lowest_set(pend_pad);
  end

  always_comb begin
    push_mask = '0;
    for (int i = 0; i < NUM_PB; i++) begin
      if (push && (push_idx == KEY_W'(i))) push_mask[i] = 1'b1;
    end
  end

  // A new press of a key that stays pending is dropped and flagged. When the
  // key is leaving for the FIFO in the same cycle the press re-arms it instead.
  assign ovf_set   = |(rise & pending_q & ~push_mask);
  assign pending_d = (pending_q & ~push_mask) | rise;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set)        ovf_d = 1'b1;
    else if (clear_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (KEY_W)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .push_i  (push),
    .din_i   (push_idx),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .dout_o  (key_code),
    .count_o (key_count)
  );

  assign key_valid = !fifo_empty;
  assign overflow  = ovf_q;

endmodule
